// File: rtl/fre_pkg.sv
// Shared constants and state encoding for the frequency calculation stage.
package fre_pkg;

  localparam int F_REF_HZ      = 100_000_000;
  localparam int FRAC_BITS_DEF = 8;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    LOAD = 2'd1,
    DIV  = 2'd2,
    DONE = 2'd3
  } fre_state_e;

endpackage

// File: rtl/seq_udiv.sv
// Bit-serial restoring divider: one quotient bit per cycle, MSB first,
// DIVIDEND_W iterations after a load. done_o marks the final iteration.
module seq_udiv #(
  parameter int DIVIDEND_W = 72,
  parameter int DIVISOR_W  = 32
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  load_i,
  input  logic [DIVIDEND_W-1:0] dividend_i,
  input  logic [DIVISOR_W-1:0]  divisor_i,
  output logic                  done_o,
  output logic [DIVIDEND_W-1:0] quotient_o,
  output logic [DIVISOR_W-1:0]  remainder_o
);

  localparam int CNT_W = $clog2(DIVIDEND_W);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DIVIDEND_W - 1);

  logic [DIVIDEND_W-1:0] num_q;
  logic [DIVIDEND_W-1:0] quo_q;
  logic [DIVISOR_W-1:0]  rem_q;
  logic [DIVISOR_W-1:0]  dvs_q;
  logic [CNT_W-1:0]      cnt_q;
  logic                  run_q;

  logic [DIVISOR_W:0]    rem_shift;
  logic [DIVISOR_W-1:0]  rem_diff_d;
  logic                  fits;

  // The stored remainder is always below the divisor, so only the shifted
  // trial value needs the extra bit; the difference always fits back in.
  always_comb begin
    rem_shift  = {rem_q, num_q[DIVIDEND_W-1]};
    fits       = (rem_shift >= {1'b0, dvs_q});
    rem_diff_d = rem_shift[DIVISOR_W-1:0] - dvs_q;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      num_q <= '0;
      quo_q <= '0;
      rem_q <= '0;
      dvs_q <= '0;
      cnt_q <= '0;
      run_q <= 1'b0;
    end else if (load_i) begin
      num_q <= dividend_i;
      dvs_q <= divisor_i;
      rem_q <= '0;
      quo_q <= '0;
      cnt_q <= CNT_LAST;
      run_q <= 1'b1;
    end else if (run_q) begin
      num_q <= {num_q[DIVIDEND_W-2:0], 1'b0};
      rem_q <= fits ? rem_diff_d : rem_shift[DIVISOR_W-1:0];
      quo_q <= {quo_q[DIVIDEND_W-2:0], fits};
      if (cnt_q == '0) begin
        run_q <= 1'b0;
      end else begin
        cnt_q <= cnt_q - 1'b1;
      end
    end
  end

  assign done_o      = run_q & (cnt_q == '0);
  assign quotient_o  = quo_q;
  assign remainder_o = rem_q;

endmodule

// File: rtl/fre_calc.sv
// Computes f = N * F_REF / M in fixed point after each falling gate edge.
// Build option FRE_CALC_ROUND_EN: round to nearest instead of truncating.
module fre_calc
  import fre_pkg::*;
#(
  parameter int F_REF     = F_REF_HZ,
  parameter int FRAC_BITS = FRAC_BITS_DEF
) (
  input  logic                    clk_100M,
  input  logic                    rst_n,
  input  logic [31:0]             M,
  input  logic [31:0]             N,
  input  logic                    gate,
  output logic [31+FRAC_BITS:0]   freq,
  output logic                    freq_valid,
  output logic                    busy,
  output logic                    div_err
);

  localparam int OUT_W = 32 + FRAC_BITS;
  localparam int NUM_W = 64 + FRAC_BITS;

  fre_state_e        state_q;
  logic              gate_pre_q;
  logic              zero_q;
  logic [OUT_W-1:0]  freq_q;
  logic              freq_valid_q;
  logic              div_err_q;
  logic              busy_q;

  logic              start;
  logic              div_load;
  logic              div_done;
  logic              overflow;
  logic [NUM_W-1:0]  num_d;
  logic [NUM_W-1:0]  quo;
  logic [31:0]       rem_unused;

  assign start    = gate_pre_q & ~gate;
  assign div_load = (state_q == LOAD);
  assign overflow = |quo[NUM_W-1:OUT_W];

  // Half the divisor added up front turns the truncating divide into round-half-up.
  always_comb begin
    num_d = (NUM_W'(N) * NUM_W'(F_REF)) << FRAC_BITS;
`ifdef FRE_CALC_ROUND_EN
    num_d = num_d + NUM_W'(M >> 1);
`endif
  end

  seq_udiv #(
    .DIVIDEND_W (NUM_W),
    .DIVISOR_W  (32)
  ) u_div (
    .clk         (clk_100M),
    .rst_n       (rst_n),
    .load_i      (div_load),
    .dividend_i  (num_d),
    .divisor_i   (M),
    .done_o      (div_done),
    .quotient_o  (quo),
    .remainder_o (rem_unused)
  );

  always_ff @(posedge clk_100M or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= IDLE;
      gate_pre_q   <= 1'b0;
      zero_q       <= 1'b0;
      freq_q       <= '0;
      freq_valid_q <= 1'b0;
      div_err_q    <= 1'b0;
      busy_q       <= 1'b0;
    end else begin
      gate_pre_q   <= gate;
      freq_valid_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (start) begin
            state_q <= LOAD;
            busy_q  <= 1'b1;
          end
        end
        LOAD: begin
          zero_q  <= (M == 32'd0);
          state_q <= DIV;
        end
        DIV: begin
          if (div_done) begin
            state_q <= DONE;
          end
        end
        DONE: begin
          // A zero divisor still runs the full divide so latency stays fixed.
          if (zero_q || overflow) begin
            freq_q    <= '1;
            div_err_q <= 1'b1;
          end else begin
            freq_q    <= quo[OUT_W-1:0];
            div_err_q <= 1'b0;
          end
          freq_valid_q <= 1'b1;
          busy_q       <= 1'b0;
          state_q      <= IDLE;
        end
        default: begin
          state_q <= IDLE;
          busy_q  <= 1'b0;
        end
      endcase
    end
  end

  assign freq       = freq_q;
  assign freq_valid = freq_valid_q;
  assign busy       = busy_q;
  assign div_err    = div_err_q;

endmodule

// File: tb/tb_fre_calc.sv
// Self-checking bench for fre_calc: directed table, hand-written corner
// sequences and random pairs checked against an arithmetic reference model.
module tb_fre_calc;

  localparam int LAT = 74;

  logic        clk_100M = 1'b0;
  logic        rst_n    = 1'b0;
  logic [31:0] M        = '0;
  logic [31:0] N        = '0;
  logic        gate     = 1'b0;
  logic [39:0] freq;
  logic        freq_valid;
  logic        busy;
  logic        div_err;

  int checks = 0;
  int errors = 0;

  always #5 clk_100M = ~clk_100M;

  fre_calc dut (
    .clk_100M   (clk_100M),
    .rst_n      (rst_n),
    .M          (M),
    .N          (N),
    .gate       (gate),
    .freq       (freq),
    .freq_valid (freq_valid),
    .busy       (busy),
    .div_err    (div_err)
  );

  typedef struct {
    logic [31:0] m;
    logic [31:0] n;
    logic [39:0] f;
    logic        e;
  } vec_t;

  vec_t vecs[5];

  task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s actual=0x%0h required=0x%0h", name, act, exp);
    end
  endtask

  // Reference: plain wide arithmetic on f = N * F_REF * 2^8 / M.
  function automatic void refModel(input logic [31:0] m, input logic [31:0] n,
                                   output logic [39:0] f, output logic e);
    logic [127:0] num;
    logic [127:0] q;
    num = (128'(n) * 128'd100_000_000) << 8;
`ifdef FRE_CALC_ROUND_EN
    num = num + 128'(m / 2);
`endif
    if (m == 32'd0) begin
      f = '1;
      e = 1'b1;
    end else begin
      q = num / 128'(m);
      if (q >= (128'd1 << 40)) begin
        f = '1;
        e = 1'b1;
      end else begin
        f = q[39:0];
        e = 1'b0;
      end
    end
  endfunction

  // Presents a pair, drops the gate, and checks busy, latency and pulse width.
  task automatic applyStimulus(input logic [31:0] m, input logic [31:0] n, input string tag,
                               output logic [39:0] gotF, output logic gotE);
    int lat;
    @(negedge clk_100M);
    M    = m;
    N    = n;
    gate = 1'b1;
    @(negedge clk_100M);
    @(negedge clk_100M);
    gate = 1'b0;
    lat  = -1;
    for (int k = 0; k < 200; k++) begin
      @(posedge clk_100M);
      #1;
      if (k == 0) checkOutput($sformatf("%s_busy_start", tag), 64'(busy), 64'd1);
      if (freq_valid) begin
        lat = k;
        break;
      end
    end
    checkOutput($sformatf("%s_latency", tag), 64'(lat), 64'(LAT));
    checkOutput($sformatf("%s_busy_done", tag), 64'(busy), 64'd0);
    gotF = freq;
    gotE = div_err;
    @(posedge clk_100M);
    #1;
    checkOutput($sformatf("%s_valid_width", tag), 64'(freq_valid), 64'd0);
  endtask

  initial begin
    logic [39:0] gotF;
    logic        gotE;
    logic [39:0] expF;
    logic        expE;
    logic [31:0] rm;
    logic [31:0] rn;
    int          pulses;
    int          lat;

    vecs[0] = '{32'd50_000_000, 32'd50_000_000, 40'h5F5E10000, 1'b0};
    vecs[1] = '{32'd50_000_000, 32'd50, 40'd25600, 1'b0};
`ifdef FRE_CALC_ROUND_EN
    vecs[2] = '{32'd50_000_001, 32'd1, 40'd512, 1'b0};
`else
    vecs[2] = '{32'd50_000_001, 32'd1, 40'd511, 1'b0};
`endif
    vecs[3] = '{32'd0, 32'd123, 40'hFFFFFFFFFF, 1'b1};
    vecs[4] = '{32'd50_000_000, 32'd50, 40'd25600, 1'b0};

    repeat (3) @(negedge clk_100M);
    checkOutput("rst_freq", 64'(freq), 64'd0);
    checkOutput("rst_valid", 64'(freq_valid), 64'd0);
    checkOutput("rst_busy", 64'(busy), 64'd0);
    checkOutput("rst_err", 64'(div_err), 64'd0);
    rst_n = 1'b1;
    repeat (2) @(negedge clk_100M);

    for (int i = 0; i < 5; i++) begin
      applyStimulus(vecs[i].m, vecs[i].n, $sformatf("vec%0d", i), gotF, gotE);
      checkOutput($sformatf("vec%0d_freq", i), 64'(gotF), 64'(vecs[i].f));
      checkOutput($sformatf("vec%0d_err", i), 64'(gotE), 64'(vecs[i].e));
    end

    // Overflow pair with a second falling gate edge while the divide runs.
    @(negedge clk_100M);
    M    = 32'd1;
    N    = 32'hFFFF_FFFF;
    gate = 1'b1;
    @(negedge clk_100M);
    @(negedge clk_100M);
    gate   = 1'b0;
    pulses = 0;
    lat    = -1;
    gotF   = '0;
    gotE   = 1'b0;
    for (int k = 0; k < 250; k++) begin
      @(posedge clk_100M);
      #1;
      if (k == 10) gate = 1'b1;
      if (k == 12) gate = 1'b0;
      if (freq_valid) begin
        pulses++;
        if (pulses == 1) begin
          lat  = k;
          gotF = freq;
          gotE = div_err;
        end
      end
    end
    checkOutput("ovf_pulses", 64'(pulses), 64'd1);
    checkOutput("ovf_latency", 64'(lat), 64'(LAT));
    checkOutput("ovf_freq", 64'(gotF), 64'hFF_FFFF_FFFF);
    checkOutput("ovf_err", 64'(gotE), 64'd1);

    // Reset in the middle of a divide.
    @(negedge clk_100M);
    M    = 32'd50_000_000;
    N    = 32'd50;
    gate = 1'b1;
    @(negedge clk_100M);
    @(negedge clk_100M);
    gate = 1'b0;
    for (int k = 0; k < 31; k++) begin
      @(posedge clk_100M);
      #1;
    end
    checkOutput("mid_busy_before", 64'(busy), 64'd1);
    rst_n = 1'b0;
    #1;
    checkOutput("mid_rst_freq", 64'(freq), 64'd0);
    checkOutput("mid_rst_busy", 64'(busy), 64'd0);
    checkOutput("mid_rst_err", 64'(div_err), 64'd0);
    checkOutput("mid_rst_valid", 64'(freq_valid), 64'd0);
    repeat (3) @(negedge clk_100M);
    rst_n  = 1'b1;
    pulses = 0;
    for (int k = 0; k < 120; k++) begin
      @(posedge clk_100M);
      #1;
      if (freq_valid) pulses++;
    end
    checkOutput("mid_no_valid", 64'(pulses), 64'd0);
    applyStimulus(32'd50_000_000, 32'd50, "post_rst", gotF, gotE);
    checkOutput("post_rst_freq", 64'(gotF), 64'd25600);
    checkOutput("post_rst_err", 64'(gotE), 64'd0);

    for (int i = 0; i < 16; i++) begin
      rn = $urandom;
      case (i % 4)
        0:       rm = $urandom_range(1, 1000);
        1:       rm = (i == 5) ? 32'd0 : $urandom_range(1, 100_000_000);
        default: rm = $urandom;
      endcase
      refModel(rm, rn, expF, expE);
      applyStimulus(rm, rn, $sformatf("rnd%0d", i), gotF, gotE);
      checkOutput($sformatf("rnd%0d_freq_m%0d_n%0d", i, rm, rn), 64'(gotF), 64'(expF));
      checkOutput($sformatf("rnd%0d_err", i), 64'(gotE), 64'(expE));
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/fre_calc.md
Name: fre_calc

Overview:
- Downstream stage of the equal-precision frequency gate.
- Consumes the gate's standard-clock count M and signal count N.
- Computes f = N * F_REF / M as unsigned fixed-point Hz using a bit-serial restoring divider.
- Presents the result with a one-cycle valid strobe to the display/UART layer.

Parameters:
- F_REF, 100_000_000: standard clock frequency in Hz (clk_100M).
- FRAC_BITS, 8: fractional bits in the result. Derived localparams:
  - OUT_W = 32 + FRAC_BITS
  - NUM_W = 64 + FRAC_BITS

Ports:
- clk_100M  in  1  system clock, 100 MHz
- rst_n  in  1  asynchronous, active-low reset
- M  in  32  standard-clock count from the gate stage; stable while gate low
- N  in  32  signal-edge count from the gate stage; stable while gate low
- gate  in  1  actual gate from the gate stage; its falling edge marks a fresh M/N pair
- freq  out  OUT_W  frequency in Hz, unsigned, FRAC_BITS fractional bits
- freq_valid  out  1  one-cycle pulse when freq/div_err update
- busy  out  1  high from LOAD through DONE
- div_err  out  1  1 = last result invalid (M==0 or quotient overflow); held until next result

Behaviour:
- Reset values (async, all registers): freq=0, freq_valid=0, busy=0, div_err=0, gate_pre=0, state=IDLE, divider registers=0.
- Start detection:
  - gate_pre registered every cycle.
  - start = gate_pre & ~gate, evaluated in IDLE only.
  - A start seen in any other state is ignored; no queueing.
- IDLE -> LOAD on start.
- LOAD (1 cycle):
  - Capture M into divisor.
  - numerator = (N * F_REF) << FRAC_BITS, NUM_W bits, unsigned, no truncation.
  - Clear remainder and quotient.
  - If M==0, set a zero-divide flag.
  - Next state is DIV.
- DIV (exactly NUM_W cycles, MSB first):
  - rem = {rem, num[msb]}; shift num left.
  - If rem >= divisor: rem -= divisor and shift in quotient bit 1, else shift in 0.
  - rem is 33 bits wide.
  - Bit counter runs NUM_W-1 down to 0; at 0 go to DONE.
  - With M==0 the DIV cycles still run (fixed latency); the result is discarded.
- DONE (1 cycle):
  - If M==0, or quotient bits [NUM_W-1:OUT_W] are non-zero: freq = all ones, div_err=1.
  - Else freq = quotient[OUT_W-1:0], div_err=0.
  - freq_valid=1 this cycle only. Next state is IDLE.
- Latency:
  - The clock edge that samples start is edge T; LOAD occupies T+1.
  - freq_valid is high in the cycle following edge T+NUM_W+2, i.e. 74 cycles after start for FRAC_BITS=8.
- busy = (state != IDLE).
- freq and div_err hold their values between results.
- Mid-operation reset: aborts immediately, all outputs return to reset values, and no freq_valid is issued for the aborted pair.
- The gate period (≥0.55 s) far exceeds the latency, so no start is lost in normal operation.

Optional Feature:
- Macro FRE_CALC_ROUND_EN.
- Defined: LOAD adds floor(M/2) to the numerator before division, so the result is rounded to nearest (ties up); overflow/saturation rules are unchanged.
- Undefined: the result is truncated toward zero.
- Latency is identical in both builds.

Decomposition:
- Package fre_pkg holds:
  - F_REF_HZ = 100_000_000
  - default FRAC_BITS
  - state encoding IDLE/LOAD/DIV/DONE, 2-bit
- Natural sub-module: seq_udiv, a parameterised restoring divider with start/done/quotient/remainder ports. fre_calc instantiates it and keeps edge detection, numerator build, saturation and output registers.

Test Plan:
- M=50_000_000, N=50_000_000, pulse gate 1->0 -> after 74 cycles freq=0x5F5E10000 (100 MHz), div_err=0, freq_valid exactly 1 cycle.
- M=50_000_000, N=50 -> freq=25600 (100.00 Hz), div_err=0.
- M=50_000_001, N=1 -> freq=511 without FRE_CALC_ROUND_EN; 512 with it.
- M=0, N=123 -> freq=all ones (0xFFFFFFFFFF), div_err=1. A following pair M=50_000_000, N=50 -> freq=25600, div_err=0.
- M=1, N=0xFFFFFFFF -> overflow: freq=all ones, div_err=1. A second gate falling edge 10 cycles after the first -> ignored, exactly one freq_valid.
- Assert rst_n low at cycle 30 of DIV -> freq=0, busy=0, no freq_valid. After release, a new pair -> correct result with normal 74-cycle latency.
